// File: rtl/fios_res_normalizer.sv
// Final stage of the FIOS Montgomery chain: resolves carry-save limbs into T < 2p,
// then streams either T or T - p word-serially, picking whichever is reduced.
module fios_res_normalizer #(
  parameter int S     = 8,
  parameter int IDX_W = $clog2(S+1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [16:0]      res_word_i,
  input  logic [16:0]      res_carry_i,
  output logic [IDX_W-1:0] p_addr_o,
  input  logic [16:0]      p_word_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [16:0]      out_word_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int AW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(S-1);

  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, OUTPUT} state_t;
  typedef struct packed {
    logic [16:0] t;
    logic [16:0] d;
  } ent_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [AW-1:0]    widx;
  logic [17:0]      carry_acc;
  logic             borrow, sel_sub;
  ent_t             buf_q [S];

  logic             acc, out_hs;
  logic [17:0]      cin, sum, d;
  logic             bin;
  logic [16:0]      t;

  assign widx     = idx[AW-1:0];
  assign acc      = res_valid_i & res_ready_o;
  assign out_hs   = out_valid_o & out_ready_i;
  assign p_addr_o = idx;

  // A limb accepted in IDLE starts a fresh operand regardless of leftover accumulators.
  assign cin = (state == IDLE) ? 18'd0 : carry_acc;
  assign bin = (state == IDLE) ? 1'b0  : borrow;
  assign sum = {1'b0, res_word_i} + cin;
  assign t   = sum[16:0];
  assign d   = {1'b0, t} - {1'b0, p_word_i} - {17'd0, bin};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    res_ready_o = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      IDLE: begin
        res_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (acc) state_nx = COLLECT;
      end
      COLLECT: begin
        res_ready_o = 1'b1;
        if (acc && idx == LAST) state_nx = DECIDE;
      end
      DECIDE: state_nx = OUTPUT;
      OUTPUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i && idx == LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      idx       <= '0;
      carry_acc <= '0;
      borrow    <= 1'b0;
      sel_sub   <= 1'b0;
    end else begin
      if (acc) begin
        carry_acc <= {1'b0, res_carry_i} + {17'd0, sum[17]};
        borrow    <= d[17];
        idx       <= idx + 1'b1;
      end
      if (state == DECIDE) begin
        // T >= p: either a top word is present or the low words did not borrow.
        sel_sub <= (carry_acc != 18'd0) | ~borrow;
        idx     <= '0;
      end
      if (out_hs) idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (acc) buf_q[widx] <= '{t: t, d: d[16:0]};
  end

  assign out_word_o = (state != OUTPUT) ? 17'd0 :
                      sel_sub ? buf_q[widx].d : buf_q[widx].t;
  assign out_last_o = (state == OUTPUT) && (idx == LAST);

endmodule

// File: tb/tb_fios_res_normalizer.sv
// Directed bench for fios_res_normalizer at S=2, p = {p1=0, p0=5}.
module tb_fios_res_normalizer;

  localparam int S     = 2;
  localparam int IDX_W = $clog2(S+1);

  logic             clock_i = 1'b0;
  logic             reset_i;
  logic             res_valid_i;
  logic             res_ready_o;
  logic [16:0]      res_word_i;
  logic [16:0]      res_carry_i;
  logic [IDX_W-1:0] p_addr_o;
  logic [16:0]      p_word_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [16:0]      out_word_o;
  logic             out_last_o;
  logic             busy_o;

  int nvec = 0;
  int nerr = 0;

  fios_res_normalizer #(.S(S), .IDX_W(IDX_W)) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .res_valid_i(res_valid_i),
    .res_ready_o(res_ready_o),
    .res_word_i (res_word_i),
    .res_carry_i(res_carry_i),
    .p_addr_o   (p_addr_o),
    .p_word_i   (p_word_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_word_o (out_word_o),
    .out_last_o (out_last_o),
    .busy_o     (busy_o)
  );

  always #5 clock_i = ~clock_i;

  assign p_word_i = (p_addr_o == '0) ? 17'd5 : 17'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One S=2 operand in, two words out; 'stall' holds out_ready_i low on word 0.
  task automatic xact(input string nm,
                      input logic [16:0] w0, input logic [16:0] c0,
                      input logic [16:0] w1, input logic [16:0] c1,
                      input logic [16:0] e0, input logic [16:0] e1,
                      input int stall);
    @(negedge clock_i);
    res_valid_i = 1'b1; res_word_i = w0; res_carry_i = c0;
    chk({nm, ".rdy0"}, res_ready_o, 1);
    chk({nm, ".paddr0"}, p_addr_o, 0);
    @(negedge clock_i);
    res_word_i = w1; res_carry_i = c1;
    chk({nm, ".rdy1"}, res_ready_o, 1);
    chk({nm, ".paddr1"}, p_addr_o, 1);
    @(negedge clock_i);
    res_valid_i = 1'b0;
    chk({nm, ".decide_vld"}, out_valid_o, 0);
    chk({nm, ".decide_rdy"}, res_ready_o, 0);
    chk({nm, ".decide_busy"}, busy_o, 1);
    @(negedge clock_i);
    chk({nm, ".vld_lat"}, out_valid_o, 1);
    for (int k = 0; k < stall; k++) begin
      out_ready_i = 1'b0;
      res_valid_i = 1'b1;
      chk({nm, ".stall_w"}, out_word_o, e0);
      chk({nm, ".stall_l"}, out_last_o, 0);
      chk({nm, ".stall_rdy"}, res_ready_o, 0);
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    out_ready_i = 1'b1;
    chk({nm, ".w0"}, out_word_o, e0);
    chk({nm, ".l0"}, out_last_o, 0);
    @(negedge clock_i);
    chk({nm, ".v1"}, out_valid_o, 1);
    chk({nm, ".w1"}, out_word_o, e1);
    chk({nm, ".l1"}, out_last_o, 1);
    @(negedge clock_i);
    out_ready_i = 1'b0;
    chk({nm, ".end_vld"}, out_valid_o, 0);
    chk({nm, ".end_busy"}, busy_o, 0);
    chk({nm, ".end_rdy"}, res_ready_o, 1);
  endtask

  initial begin
    reset_i = 1'b1; res_valid_i = 1'b0; res_word_i = '0; res_carry_i = '0;
    out_ready_i = 1'b0;
    #12;
    chk("rst.vld",   out_valid_o, 0);
    chk("rst.last",  out_last_o, 0);
    chk("rst.word",  out_word_o, 0);
    chk("rst.busy",  busy_o, 0);
    chk("rst.paddr", p_addr_o, 0);
    chk("rst.rdy",   res_ready_o, 1);
    @(negedge clock_i);
    reset_i = 1'b0;

    // T=3 < p: pass-through
    xact("lt",   17'd3, 17'd0, 17'd0, 17'd0, 17'd3, 17'd0, 0);
    // T={7,1} after carry resolution, T-p={2,1}
    xact("sub",  17'd7, 17'd1, 17'd0, 17'd0, 17'd2, 17'd1, 0);
    // Top carry set: output T-p with the top word dropped
    xact("top",  17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'd0, 17'h1FFFA, 17'h1FFFE, 0);
    // T == p exactly reduces to zero
    xact("eq",   17'd5, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 0);
    // Backpressure on word 0 with upstream also pending
    xact("bp",   17'd7, 17'd1, 17'd0, 17'd0, 17'd2, 17'd1, 3);

    // Abort after one limb that leaves carry_acc=1, borrow=0
    @(negedge clock_i);
    res_valid_i = 1'b1; res_word_i = 17'd7; res_carry_i = 17'd1;
    @(negedge clock_i);
    res_valid_i = 1'b0;
    chk("abort.busy_pre", busy_o, 1);
    reset_i = 1'b1;
    #1;
    chk("abort.busy", busy_o, 0);
    chk("abort.paddr", p_addr_o, 0);
    chk("abort.vld", out_valid_o, 0);
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("abort.rdy", res_ready_o, 1);
    xact("post", 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'd0, 17'h1FFFA, 17'h1FFFE, 0);
    xact("post2", 17'd3, 17'd0, 17'd0, 17'd0, 17'd3, 17'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
